// File: rtl/alu_md_pkg.sv
// Shared constants for the ALU control decoder and the HI/LO multiply/divide engine.
// Optional build macro ALU_MD_DIVZERO_FLAG_EN adds a div_zero result flag.
package alu_md_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_XOR  = 4'b0011;
  localparam logic [3:0] ALUC_NOR  = 4'b0100;
  localparam logic [3:0] ALUC_SUB  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_SLTU = 4'b1000;
  localparam logic [3:0] ALUC_SLL  = 4'b1001;
  localparam logic [3:0] ALUC_SRL  = 4'b1010;
  localparam logic [3:0] ALUC_SRA  = 4'b1011;
  localparam logic [3:0] ALUC_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    logic [3:0] code;
    code = ALUC_NOP;
    case (aluop)
      ALUOP_MEM:    code = ALUC_ADD;
      ALUOP_BRANCH: code = ALUC_SUB;
      ALUOP_RSVD:   code = ALUC_AND;
      default: begin
        case (fn)
          F_ADD, F_ADDU: code = ALUC_ADD;
          F_SUB, F_SUBU: code = ALUC_SUB;
          F_AND:         code = ALUC_AND;
          F_OR:          code = ALUC_OR;
          F_XOR:         code = ALUC_XOR;
          F_NOR:         code = ALUC_NOR;
          F_SLT:         code = ALUC_SLT;
          F_SLTU:        code = ALUC_SLTU;
          F_SLL:         code = ALUC_SLL;
          F_SRL:         code = ALUC_SRL;
          F_SRA:         code = ALUC_SRA;
          default:       code = ALUC_NOP;
        endcase
      end
    endcase
    return code;
  endfunction

  function automatic logic is_md_funct(input logic [5:0] fn);
    return (fn == F_MULT) || (fn == F_MULTU) || (fn == F_DIV) || (fn == F_DIVU) ||
           (fn == F_MTHI) || (fn == F_MTLO) || (fn == F_MFHI) || (fn == F_MFLO);
  endfunction

endpackage

// File: rtl/alu_md_decoder_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
// Optional build macro ALU_MD_DIVZERO_FLAG_EN adds the div_zero output.
//
//  state | meaning
//  IDLE  | waiting for start; operands latched on accept
//  RUN   | one multiply or divide iteration per cycle, WIDTH cycles
//  FIX   | signed correction applied; result written out on the next edge
module muldiv_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             flush,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             wr_en,
  output logic             done,
`ifdef ALU_MD_DIVZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t        state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             op_div, neg_q, neg_r, b_zero;
  logic             sa, sb, accept, last_iter;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign accept    = (state == ST_IDLE) & start & ~flush;
  assign last_iter = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN: begin
        if (flush)          state_nx = ST_IDLE;
        else if (last_iter) state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    wr_en = (state == ST_FIX) & ~flush;
  end

  // Multiply: {acc_hi,acc_lo} shifts right with the multiplier in acc_lo.
  // Divide: {acc_hi,acc_lo} shifts left, acc_hi is the partial remainder.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= sa ? -a : a;
      opb    <= sb ? -b : b;
      op_div <= is_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      b_zero <= (b == '0);
    end else if (state == ST_RUN) begin
      cnt <= cnt + 1'b1;
      if (op_div) begin
        if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // A zero divisor leaves |a| as remainder; restoring its sign reproduces a.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -acc_lo : acc_lo;
    r_fix    = neg_r ? -acc_hi : acc_hi;
    if (op_div) begin
      res_hi = r_fix;
      res_lo = b_zero ? '1 : q_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done <= 1'b0;
`ifdef ALU_MD_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= wr_en;
`ifdef ALU_MD_DIVZERO_FLAG_EN
      div_zero <= wr_en & op_div & b_zero;
`endif
    end
  end

endmodule

// File: rtl/alu_md_decoder.sv
// EX-stage ALU control decoder with HI/LO registers and a multi-cycle mul/div engine.
// Optional build macro ALU_MD_DIVZERO_FLAG_EN adds the div_zero output.
module alu_md_decoder
  import alu_md_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic              op_valid,
  input  logic              flush,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              ready,
  output logic              busy,
  output logic              done,
`ifdef ALU_MD_DIVZERO_FLAG_EN
  output logic              div_zero,
`endif
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              hilo_stall
);

  logic             rtype, md_op, muldiv_op, start, is_div, is_signed, wr_en;
  logic             wr_mthi, wr_mtlo;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign ALUControl = CTRL_W'(alu_decode(ALUOp, funct));

  assign rtype     = op_valid & (ALUOp == ALUOP_RTYPE);
  assign md_op     = rtype & is_md_funct(funct);
  assign muldiv_op = rtype & ((funct == F_MULT) | (funct == F_MULTU) |
                              (funct == F_DIV)  | (funct == F_DIVU));
  assign is_div    = (funct == F_DIV) | (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) | (funct == F_DIV);
  assign start     = muldiv_op & ~busy & ~flush;
  assign wr_mthi   = rtype & (funct == F_MTHI) & ~busy & ~flush;
  assign wr_mtlo   = rtype & (funct == F_MTLO) & ~busy & ~flush;

  assign ready      = ~busy;
  assign hilo_stall = md_op & busy;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .flush     (flush),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (src_a),
    .b         (src_b),
    .busy      (busy),
    .wr_en     (wr_en),
    .done      (done),
`ifdef ALU_MD_DIVZERO_FLAG_EN
    .div_zero  (div_zero),
`endif
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // mthi/mtlo only land while idle, so they never collide with an engine write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_en) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (wr_mthi) hi <= src_a;
      if (wr_mtlo) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_alu_md_decoder.sv
// Directed + randomized bench for alu_md_decoder against an arithmetic reference model.
module tb_alu_md_decoder;

  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] MTHI = 6'b010001, MTLO = 6'b010011, MFHI = 6'b010000;

  logic        clk, resetn, op_valid, flush;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, hi, lo;
  logic [3:0]  ALUControl;
  logic        ready, busy, done, hilo_stall;
`ifdef ALU_MD_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_hi, ref_lo;

  alu_md_decoder #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ALUOp      (ALUOp),
    .funct      (funct),
    .op_valid   (op_valid),
    .flush      (flush),
    .src_a      (src_a),
    .src_b      (src_b),
    .ALUControl (ALUControl),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
`ifdef ALU_MD_DIVZERO_FLAG_EN
    .div_zero   (div_zero),
`endif
    .hi         (hi),
    .lo         (lo),
    .hilo_stall (hilo_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (f)
      MULT:  res = 64'(sa * sb);
      MULTU: res = ua * ub;
      DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    op_valid = 1'b0;
    ALUOp    = 2'b00;
    funct    = 6'b0;
    flush    = 1'b0;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    ALUOp    = 2'b10;
    funct    = f;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n, t;
    exp = ref_md(f, a, b);
    check("ready_before", ready, 1);
    issue(f, a, b);
    @(negedge clk);
    idle_inputs();
    n = 0;
    t = 0;
    while (!done && t < 100) begin
      t++;
      if (busy) n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 33);
    check("done_seen", done, 1);
    check("hi_result", hi, exp[63:32]);
    check("lo_result", lo, exp[31:0]);
`ifdef ALU_MD_DIVZERO_FLAG_EN
    check("div_zero", div_zero, ((f == DIV || f == DIVU) && b == 0) ? 1 : 0);
`endif
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_after", busy, 0);
  endtask

  logic [5:0] tf [13] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                          6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011};
  logic [3:0] tc [13] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001,
                          4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

  initial begin
    logic [63:0] exp;
    logic [5:0]  rf;
    logic [3:0]  rc;
    logic [5:0]  ops [4];
    int st, t, dn;
    ops = '{MULT, MULTU, DIV, DIVU};

    resetn = 1'b0;
    idle_inputs();
    src_a = '0;
    src_b = '0;
    ref_hi = '0;
    ref_lo = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Combinational decode
    for (int i = 0; i < 13; i++) begin
      ALUOp = 2'b10;
      funct = tf[i];
      #1 check("dec_rtype", ALUControl, tc[i]);
    end
    ALUOp = 2'b10; funct = 6'b001000;
    #1 check("dec_jr_nop", ALUControl, 4'b1111);
    for (int i = 0; i < 20; i++) begin
      rf = 6'($urandom_range(0, 63));
      rc = 4'b1111;
      for (int j = 0; j < 13; j++) if (tf[j] == rf) rc = tc[j];
      ALUOp = 2'b10; funct = rf;
      #1 check("dec_rand", ALUControl, rc);
      ALUOp = 2'b00;
      #1 check("dec_mem", ALUControl, 4'b0010);
      ALUOp = 2'b01;
      #1 check("dec_branch", ALUControl, 4'b0110);
      ALUOp = 2'b11;
      #1 check("dec_rsvd", ALUControl, 4'b0000);
    end
    idle_inputs();
    @(negedge clk);

    // Directed mul/div
    run_md(MULT, 32'hFFFF_FFFD, 32'd5);
    run_md(MULTU, 32'hFFFF_FFFF, 32'd2);
    run_md(DIVU, 32'd7, 32'd2);
    run_md(DIV, 32'hFFFF_FFF9, 32'd2);
    run_md(DIV, 32'd7, 32'd0);
    run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(DIVU, 32'hDEAD_BEEF, 32'd0);
    run_md(DIV, 32'hFFFF_FFF0, 32'd0);

    for (int i = 0; i < 8; i++)
      run_md(ops[$urandom_range(0, 3)], $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);

    // mthi / mtlo / mfhi
    issue(MTHI, 32'h1234, 32'h0);
    #1 check("mthi_nostall", hilo_stall, 0);
    @(negedge clk);
    idle_inputs();
    ref_hi = 32'h1234;
    check("mthi_hi", hi, ref_hi);
    check("mthi_lo_kept", lo, ref_lo);
    check("mthi_nodone", done, 0);
    exp[31:0] = $urandom;
    issue(MTLO, exp[31:0], 32'h0);
    @(negedge clk);
    idle_inputs();
    ref_lo = exp[31:0];
    check("mtlo_lo", lo, ref_lo);
    issue(MTHI, 32'hAAAA_5555, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("mthi_flushed", hi, ref_hi);
    issue(MFHI, 32'h0, 32'h0);
    #1 check("mfhi_idle", hi, ref_hi);
    check("mfhi_nostall", hilo_stall, 0);
    @(negedge clk);
    idle_inputs();

    // Flush blocks acceptance in IDLE
    issue(MULT, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("flush_idle_busy", busy, 0);
    check("flush_idle_hi", hi, ref_hi);

    // Flush mid-run
    issue(MULT, $urandom, $urandom);
    @(negedge clk);
    idle_inputs();
    check("flush_run_busy", busy, 1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", ready, 1);
    check("flush_busy", busy, 0);
    check("flush_hi", hi, ref_hi);
    check("flush_lo", lo, ref_lo);
    dn = 0;
    for (int i = 0; i < 36; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("flush_nodone", dn, 0);
    check("flush_hi_later", hi, ref_hi);
    run_md(MULT, 32'd12345, 32'hFFFF_FF00);

    // mfhi held while busy stalls until the result lands
    exp = ref_md(MULT, 32'hFFFF_FFFF, 32'd7);
    issue(MULT, 32'hFFFF_FFFF, 32'd7);
    @(negedge clk);
    funct = MFHI;
    st = 0;
    t = 0;
    while (!done && t < 100) begin
      t++;
      if (hilo_stall) st++;
      @(negedge clk);
    end
    check("stall_cycles", st, 33);
    check("stall_release", hilo_stall, 0);
    check("mfhi_done_hi", hi, exp[63:32]);
    check("mfhi_done_lo", lo, exp[31:0]);
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    idle_inputs();
    @(negedge clk);

    // Asynchronous reset mid-divide
    issue(DIV, 32'd1000, 32'd7);
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    run_md(DIVU, 32'd7, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
